mult: RTL and testbench
=======================

# mult

Sequential signed 32×32 multiplier for the multicycle datapath. It is the companion of the divider on the HI/LO path: the control unit pulses a start, the block runs radix-2 Booth iterations one bit per clock, then presents a 64-bit signed product split into HI and LO with a one-cycle completion pulse. The control unit waits on that pulse before writing HI/LO, the same way it handles the divider.

## Interface
- No parameters; operand width fixed at 32, product width 64.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- a  in  32  multiplicand, two's complement, sampled only at start
- b  in  32  multiplier, two's complement, sampled only at start
- multControl  in  1  start request, sampled each rising edge
- multBusy  out  1  high while iterations are in progress
- multStop  out  1  one-cycle completion pulse; HI/LO valid from this cycle on
- hiMult  out  32  product bits [63:32]
- loMult  out  32  product bits [31:0]

## Operation
- Reset (reset=0, async): state IDLE; multBusy=0, multStop=0, hiMult=0, loMult=0; counter, accumulator, operand registers all 0.
- States: IDLE, RUN, DONE.
  - IDLE: outputs hold. multControl=1 → load, go RUN.
  - RUN: one Booth step per edge. After the 32nd step, write the result and go DONE.
  - DONE: lasts exactly one cycle with multStop=1, then IDLE. multControl=1 in DONE → load, go RUN (multStop still drops on that edge).
- Load on the start edge:
  - M ← sign-extend(a) to 33 bits
  - A ← 33'b0; Q ← b; Q₋₁ ← 0; counter ← 32.
- Booth step, based on {Q[0], Q₋₁}:
  - 01 → A ← A + M
  - 10 → A ← A − M
  - 00/11 → no change
  - Then arithmetic shift right of {A, Q, Q₋₁} by 1 (A[32] replicated) and counter ← counter − 1.
- Result at the 32nd step: {hiMult, loMult} ← {A[31:0], Q} after the final shift. This is the exact signed product, with no overflow or exception.
- The 33-bit A is mandatory so that a = −2³¹ cannot overflow on A − M.
- hiMult/loMult change only on completion or reset. They hold the previous result through a new run and are not cleared at start.
- multControl=1 during RUN: the current operation is abandoned without a multStop. Operands are reloaded and the count restarts at 32.
- a/b changes after the start edge have no effect.

## Timing
- Start edge E0 (multControl=1 sampled): multBusy=1 from E0 through E32.
- Steps execute on E1..E32. hiMult/loMult are updated at E32.
- multStop=1 and multBusy=0 from E32 to E33. multStop is 0 again after E33 unless the product completes again.
- Latency: multStop is visible 32 cycles after the start edge. Issue rate: one multiply per 33 cycles; back-to-back is allowed by asserting start in the DONE cycle.
- multControl held high continuously keeps restarting; multStop never fires.
- Reset asserted mid-RUN: all outputs return to 0 immediately and no multStop is emitted. After deassertion the block is in IDLE and needs a fresh start.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then a=3, b=5, one-cycle start → multStop exactly 32 cycles later for one cycle; hi=0x00000000, lo=0x0000000F; multBusy high for cycles 0–31.
- a=−7 (0xFFFFFFF9), b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6; then a=0x7FFFFFFF, b=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- a=b=0x80000000 → hi=0x40000000, lo=0x00000000. Also a=0x80000000, b=1 → hi=0xFFFFFFFF, lo=0x80000000.
- Start 3×5, re-assert start with a=2, b=4 at cycle 10 → no multStop near cycle 32; one multStop 32 cycles after the second start; lo=8; hi/lo stay 0x0F until then.
- Drive reset=0 at cycle 15 of a run, asynchronous to clk → multBusy, multStop, hiMult, loMult all 0 before the next edge. Release, start a=−1, b=−1 → hi=0, lo=1 after 32 cycles.
- Assert start in the DONE cycle (back-to-back 3×5 then 4×4) → multStop pulses 32 cycles and 65 cycles after the first start; lo=0x0F then 0x10.

Source files
------------

// File: rtl/mult.sv
// mult: sequential signed 32x32 radix-2 Booth multiplier, one step per clock, 64-bit result on hiMult/loMult.
//   clk          system clock, rising edge
//   reset        asynchronous, active-low clear of all state
//   a, b         signed multiplicand / multiplier, captured on the start edge
//   multControl  start request; restarts any run in progress
//   multBusy     high while Booth steps are in progress
//   multStop     one-cycle completion pulse, product valid from then on
//   hiMult       product bits [63:32]
//   loMult       product bits [31:0]
module mult (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        multControl,
    output logic        multBusy,
    output logic        multStop,
    output logic [31:0] hiMult,
    output logic [31:0] loMult
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state, state_next;
    logic [32:0] m, acc, sum, acc_step;
    logic [31:0] q, q_step;
    logic        q_1, last;
    logic [5:0]  count;
    // 33-bit accumulator keeps A - M exact when a = -2^31.
    always_comb begin
        sum      = (q[0] & ~q_1) ? acc - m : (~q[0] & q_1) ? acc + m : acc;
        acc_step = {sum[32], sum[32:1]};
        q_step   = {sum[0], q[31:1]};
        last     = count == 6'd1;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_next;
    always_comb
        state_next = multControl ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    always_comb begin
        multBusy = state == RUN;
        multStop = state == DONE;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            m      <= '0;
            acc    <= '0;
            q      <= '0;
            q_1    <= 1'b0;
            count  <= '0;
            hiMult <= '0;
            loMult <= '0;
        end else if (multControl) begin
            m     <= {a[31], a};
            acc   <= '0;
            q     <= b;
            q_1   <= 1'b0;
            count <= 6'd32;
        end else if (state == RUN) begin
            acc   <= acc_step;
            q     <= q_step;
            q_1   <= q[0];
            count <= count - 6'd1;
            if (last) {hiMult, loMult} <= {acc_step[31:0], q_step};
        end
endmodule

// File: tb/tb_mult.sv
// tb_mult: randomized self-checking bench for mult against a plain signed-multiply reference.
module tb_mult;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        multControl = 1'b0;
    logic        multBusy, multStop;
    logic [31:0] hiMult, loMult;
    logic [63:0] last_prod = '0;
    int          checks = 0, errors = 0;

    mult dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .multControl(multControl),
        .multBusy(multBusy), .multStop(multStop), .hiMult(hiMult), .loMult(loMult)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint px, py;
        px = longint'($signed(x));
        py = longint'($signed(y));
        return 64'(px * py);
    endfunction

    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x; b = y; multControl = 1'b1;
        @(posedge clk);
        #1 multControl = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    // Counts edges after the start edge until multStop, checking hi/lo hold meanwhile.
    task automatic wait_stop(output int n);
        bit held = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
            if (!multStop && {hiMult, loMult} !== last_prod) held = 1'b0;
        end while (!multStop && n < 40);
        check("hold", 64'(held), 64'd1);
    endtask

    task automatic mul_op(input logic [31:0] x, input logic [31:0] y);
        int n;
        logic [63:0] exp;
        exp = ref_mul(x, y);
        start_op(x, y);
        check("busy_start", {62'd0, multBusy, multStop}, 64'b10);
        wait_stop(n);
        check("latency", 64'(n), 64'd32);
        check("done_flags", {62'd0, multBusy, multStop}, 64'b01);
        check("product", {hiMult, loMult}, exp);
        last_prod = exp;
        @(posedge clk);
        #1 check("stop_drop", {62'd0, multBusy, multStop}, 64'b00);
        check("product_held", {hiMult, loMult}, exp);
    endtask

    initial begin
        int n;
        #12;
        check("reset_state", {30'd0, multBusy, multStop, hiMult}, 64'd0);
        check("reset_lo", 64'(loMult), 64'd0);
        @(negedge clk) reset = 1'b1;

        mul_op(32'd3, 32'd5);
        mul_op(32'hFFFFFFF9, 32'd6);
        mul_op(32'h7FFFFFFF, 32'h7FFFFFFF);
        mul_op(32'h80000000, 32'h80000000);
        mul_op(32'h80000000, 32'd1);
        mul_op(32'd3, 32'd5);

        // restart mid-run: first run abandoned, no pulse
        start_op(32'd3, 32'd5);
        repeat (9) @(posedge clk);
        start_op(32'd2, 32'd4);
        wait_stop(n);
        check("restart_latency", 64'(n), 64'd32);
        check("restart_product", {hiMult, loMult}, 64'd8);
        last_prod = 64'd8;

        // back-to-back via start in DONE
        start_op(32'd3, 32'd5);
        wait_stop(n);
        check("b2b_first_latency", 64'(n), 64'd32);
        check("b2b_first", {hiMult, loMult}, 64'h0F);
        last_prod = 64'h0F;
        a = 32'd4; b = 32'd4; multControl = 1'b1;
        @(posedge clk);
        #1 multControl = 1'b0;
        check("b2b_restart_flags", {62'd0, multBusy, multStop}, 64'b10);
        wait_stop(n);
        check("b2b_second_latency", 64'(n), 64'd32);
        check("b2b_second", {hiMult, loMult}, 64'h10);
        last_prod = 64'h10;

        // async reset mid-run
        start_op(32'd3, 32'd5);
        repeat (14) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("async_reset", {30'd0, multBusy, multStop, hiMult}, 64'd0);
        check("async_reset_lo", 64'(loMult), 64'd0);
        last_prod = '0;
        @(negedge clk) reset = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("idle_after_reset", {62'd0, multBusy, multStop}, 64'b00);
        mul_op(32'hFFFFFFFF, 32'hFFFFFFFF);

        for (int i = 0; i < 25; i++) mul_op($urandom, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
